nn_ram_arbiter: RTL and testbench
=================================

Name: nn_ram_arbiter

Overview:
- Shares the single-port 1024x8 neural-network weight/data RAM between two requesters: the host (ARM core, memory-mapped load/store) and the neural control unit.
- Two-way round-robin with a burst cap and an inference lock that blocks the host while the accelerator runs.
- Sits between both requesters and the RAM.
- Accepts one access per cycle and returns read data one cycle after acceptance to the requester that issued the read.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 8, RAM data width.
- MAX_BURST, 16, consecutive beats one owner may take while the other side is waiting (range 1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- inference_active  in  1  high while an inference runs; host gets no grants
- host_req  in  1  host access request, held until granted
- host_we  in  1  host write enable (qualifies the beat)
- host_addr  in  ADDR_W  host address
- host_wd  in  DATA_W  host write data
- host_gnt  out  1  host beat accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rd  out  DATA_W  host read data
- nn_req, nn_we, nn_addr, nn_wd, nn_gnt, nn_rvalid, nn_rd  same as the host_* ports, for the control unit
- RAM_we  out  1  RAM write enable
- RAM_address  out  ADDR_W  RAM address
- RAM_wd  out  DATA_W  RAM write data
- RAM_rd  in  DATA_W  RAM read data, synchronous read with 1-cycle latency
- busy  out  1  owner is not NONE

Behaviour:
- State registers:
  - owner in {NONE, HOST, NN}
  - last, the most recently served side
  - burst_cnt, 8 bits, beats granted to the current owner
  - rsp_pend and rsp_who, for the read response
- Effective requests:
  - eh = host_req & ~inference_active
  - en = nn_req
- Combinational selection sel, in this order:
  - owner X with req_X, where (burst_cnt < MAX_BURST) or the other side's effective request is low -> X.
  - Otherwise, if only one of eh/en is high -> that side.
  - If both are high -> the side that is not last; the burst-expired case always picks the other side.
  - Neither high -> NONE.
- Grants and RAM drive:
  - host_gnt = (sel==HOST); nn_gnt = (sel==NN). Grants are combinational, so a request in an idle cycle is granted in the same cycle (zero-wait).
  - RAM_we/RAM_address/RAM_wd come from the selected requester. When sel==NONE: RAM_we=0, address and data hold 0.
- Clock edge:
  - owner <= sel.
  - If sel != NONE, last <= sel.
  - burst_cnt <= 1 if sel differs from owner, burst_cnt+1 (saturating at 255) if the same, 0 if NONE.
- Read response:
  - An accepted beat with we=0 sets rsp_pend=1 and rsp_who=sel on the next edge; otherwise rsp_pend=0.
  - X_rvalid = rsp_pend & (rsp_who==X).
  - X_rd = RAM_rd when X_rvalid, else 0.
  - Back-to-back reads give rvalid on consecutive cycles. One-cycle latency is fixed.
- Writes: no response; the write completes at the grant cycle's clock edge.
- inference_active:
  - Rising mid-host-burst: the host loses its grant in that same cycle; the host beat is not accepted.
  - A host read response already pending is still delivered.
- Simultaneous requests when neither side has been served since reset: NN wins (last resets to HOST).
- MAX_BURST=1: strict alternation whenever both sides request.
- Requester contract: addr/we/wd stay stable while req is high and gnt is low. The arbiter does not check this.
- Reset (asynchronous, active-low), immediate:
  - owner=NONE, last=HOST, burst_cnt=0, rsp_pend=0.
  - All outputs 0.
  - An in-flight read is dropped with no rvalid. Reset mid-burst discards ownership.

Decomposition:
- Package nn_pkg holds:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_HOST, OWN_NN}
  - constants NN_ADDR_W=10, NN_DATA_W=8
- One sub-module, arb2_rr: a combinational two-way picker with inputs (owner, last, burst_expired, eh, en) and output sel.
- The read-response tracking and RAM mux stay in the top level.

Test Plan:
- Idle host single read: host_req=1, addr=0x05 at cycle 0 -> host_gnt=1 in cycle 0; RAM_address=0x05, RAM_we=0; host_rvalid=1 in cycle 1 with host_rd equal to RAM content (preload 0xA7).
- Tie after reset: host_req and nn_req rise in the same cycle -> nn_gnt first (last=HOST). When nn drops req, host_gnt comes the next cycle.
- Burst cap: MAX_BURST=4, nn_req held with host_req held -> grant pattern NN,NN,NN,NN,HOST,...; the host streams until it drops req or reaches its own cap of 4.
- Inference lock: inference_active=1 with host_req=1 for 20 cycles -> host_gnt stays 0. When inference_active falls, host_gnt=1 in the same cycle. A host write of 0x3C to 0x3FF then reads back 0x3C.
- Interleaved reads: alternate grants HOST(0x010), NN(0x011) -> host_rvalid in cycle 1 with mem[0x010], nn_rvalid in cycle 2 with mem[0x011]; never both rvalids in the same cycle.
- Reset mid-operation: assert reset in the cycle after a granted NN read -> nn_rvalid stays 0 and all outputs read 0 immediately. After release, a tie grants NN.

Source files
------------

// File: rtl/nn_ram_arbiter_pkg.sv
// Shared types and default widths for the NN RAM arbiter.
package nn_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_HOST = 2'd1,
    OWN_NN   = 2'd2
  } owner_t;

  localparam int NN_ADDR_W = 10;
  localparam int NN_DATA_W = 8;

endpackage

// File: rtl/nn_ram_arbiter_if.sv
// Requester, lock and RAM-side signals of the NN RAM arbiter.
// The arbiter uses the slave view; the requesters, lock source and RAM use the master view.
interface nn_ram_arbiter_if #(
  parameter int ADDR_W = nn_pkg::NN_ADDR_W,
  parameter int DATA_W = nn_pkg::NN_DATA_W
);
  logic              inference_active;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wd;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rd;

  logic              nn_req;
  logic              nn_we;
  logic [ADDR_W-1:0] nn_addr;
  logic [DATA_W-1:0] nn_wd;
  logic              nn_gnt;
  logic              nn_rvalid;
  logic [DATA_W-1:0] nn_rd;

  logic              RAM_we;
  logic [ADDR_W-1:0] RAM_address;
  logic [DATA_W-1:0] RAM_wd;
  logic [DATA_W-1:0] RAM_rd;

  logic              busy;

  modport slave (
    input  inference_active,
    input  host_req, host_we, host_addr, host_wd,
    output host_gnt, host_rvalid, host_rd,
    input  nn_req, nn_we, nn_addr, nn_wd,
    output nn_gnt, nn_rvalid, nn_rd,
    output RAM_we, RAM_address, RAM_wd,
    input  RAM_rd,
    output busy
  );

  modport master (
    output inference_active,
    output host_req, host_we, host_addr, host_wd,
    input  host_gnt, host_rvalid, host_rd,
    output nn_req, nn_we, nn_addr, nn_wd,
    input  nn_gnt, nn_rvalid, nn_rd,
    input  RAM_we, RAM_address, RAM_wd,
    output RAM_rd,
    input  busy
  );

endinterface

// File: rtl/nn_ram_arbiter_arb2_rr.sv
// Two-way round-robin picker: the current owner keeps the RAM until its
// burst cap expires while the other side waits; ties go to the side not served last.
module arb2_rr
  import nn_pkg::*;
(
  input  owner_t i_owner,
  input  owner_t i_last,
  input  logic   i_burst_expired,
  input  logic   i_eh,
  input  logic   i_en,
  output owner_t o_sel
);

  // Priority-ordered pick; an expired owner has last==owner, so the tie rule hands over.
  always_comb begin
    o_sel = OWN_NONE;
    if (i_owner == OWN_HOST && i_eh && (!i_burst_expired || !i_en))
      o_sel = OWN_HOST;
    else if (i_owner == OWN_NN && i_en && (!i_burst_expired || !i_eh))
      o_sel = OWN_NN;
    else if (i_eh && !i_en)
      o_sel = OWN_HOST;
    else if (i_en && !i_eh)
      o_sel = OWN_NN;
    else if (i_eh && i_en)
      o_sel = (i_last == OWN_NN) ? OWN_HOST : OWN_NN;
  end

endmodule

// File: rtl/nn_ram_arbiter.sv
// Shares the single-port NN weight/data RAM between the host and the neural
// control unit. Grants are combinational (zero-wait); read data returns one
// cycle after acceptance to the side that issued the read.
//
// owner     | meaning
// ----------+-------------------------------------------------
// OWN_NONE  | no beat accepted last cycle, RAM idle
// OWN_HOST  | host took the last beat, may continue its burst
// OWN_NN    | control unit took the last beat, may continue
module nn_ram_arbiter
  import nn_pkg::*;
#(
  parameter int ADDR_W    = NN_ADDR_W,
  parameter int DATA_W    = NN_DATA_W,
  parameter int MAX_BURST = 16
) (
  input logic              clk,
  input logic              reset,
  nn_ram_arbiter_if.slave  bus
);

  owner_t     r_owner;
  owner_t     r_last;
  logic [7:0] r_burst_cnt;
  logic       r_rsp_pend;
  owner_t     r_rsp_who;

  logic       w_eh;
  logic       w_en;
  logic       w_burst_expired;
  owner_t     w_pick;
  owner_t     w_sel;

  assign w_eh            = bus.host_req & ~bus.inference_active;
  assign w_en            = bus.nn_req;
  assign w_burst_expired = (r_burst_cnt >= 8'(MAX_BURST));

  arb2_rr u_arb2_rr (
    .i_owner         (r_owner),
    .i_last          (r_last),
    .i_burst_expired (w_burst_expired),
    .i_eh            (w_eh),
    .i_en            (w_en),
    .o_sel           (w_pick)
  );

  // Reset blocks every grant so all outputs are zero the moment reset asserts.
  assign w_sel = reset ? w_pick : OWN_NONE;

  // Grants, RAM mux and read-data steering.
  always_comb begin
    bus.host_gnt    = (w_sel == OWN_HOST);
    bus.nn_gnt      = (w_sel == OWN_NN);
    bus.RAM_we      = 1'b0;
    bus.RAM_address = '0;
    bus.RAM_wd      = '0;
    case (w_sel)
      OWN_HOST: begin
        bus.RAM_we      = bus.host_we;
        bus.RAM_address = bus.host_addr;
        bus.RAM_wd      = bus.host_wd;
      end
      OWN_NN: begin
        bus.RAM_we      = bus.nn_we;
        bus.RAM_address = bus.nn_addr;
        bus.RAM_wd      = bus.nn_wd;
      end
      default: ;
    endcase
    bus.host_rvalid = r_rsp_pend && (r_rsp_who == OWN_HOST);
    bus.nn_rvalid   = r_rsp_pend && (r_rsp_who == OWN_NN);
    bus.host_rd     = bus.host_rvalid ? bus.RAM_rd : '0;
    bus.nn_rd       = bus.nn_rvalid   ? bus.RAM_rd : '0;
    bus.busy        = (r_owner != OWN_NONE);
  end

  // Ownership, round-robin history, burst length and read-response tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner     <= OWN_NONE;
      r_last      <= OWN_HOST;
      r_burst_cnt <= 8'd0;
      r_rsp_pend  <= 1'b0;
      r_rsp_who   <= OWN_NONE;
    end else begin
      r_owner <= w_sel;
      if (w_sel != OWN_NONE)
        r_last <= w_sel;
      if (w_sel == OWN_NONE)
        r_burst_cnt <= 8'd0;
      else if (w_sel != r_owner)
        r_burst_cnt <= 8'd1;
      else if (r_burst_cnt != 8'hFF)
        r_burst_cnt <= r_burst_cnt + 8'd1;
      r_rsp_pend <= (w_sel != OWN_NONE) && !bus.RAM_we;
      r_rsp_who  <= w_sel;
    end
  end

endmodule

// File: tb/tb_nn_ram_arbiter.sv
// Scoreboard bench for nn_ram_arbiter: a cycle-level reference model predicts
// grants, RAM drive and read responses; a separate monitor checks responses.
module tb_nn_ram_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 8;
  localparam int MAXB = 4;
  localparam int M_NONE = 0, M_HOST = 1, M_NN = 2;

  logic clk;
  logic reset;

  nn_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  nn_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: synchronous write, synchronous read with one-cycle latency.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.RAM_we) ram[bus.RAM_address] <= bus.RAM_wd;
    bus.RAM_rd <= ram[bus.RAM_address];
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state.
  int m_owner = M_NONE;
  int m_last  = M_HOST;
  int m_streak = 0;
  logic [DW-1:0] m_mem [0:(1<<AW)-1];

  typedef struct { int who; int data; int due; } rsp_t;
  rsp_t q[$];

  function automatic int model_pick(input bit eh, input bit en);
    if (!eh && !en) return M_NONE;
    if (eh && !en)  return M_HOST;
    if (en && !eh)  return M_NN;
    if (m_owner != M_NONE && m_streak < MAXB) return m_owner;
    return (m_last == M_NN) ? M_HOST : M_NN;
  endfunction

  // Grant / RAM-drive checker and model update.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_host_gnt", bus.host_gnt, 0);
      chk("rst_nn_gnt", bus.nn_gnt, 0);
      chk("rst_ram_we", bus.RAM_we, 0);
      chk("rst_ram_addr", bus.RAM_address, 0);
      chk("rst_ram_wd", bus.RAM_wd, 0);
      chk("rst_busy", bus.busy, 0);
      m_owner = M_NONE; m_last = M_HOST; m_streak = 0;
    end else begin
      bit eh, en, we;
      int s, a, d;
      eh = bus.host_req && !bus.inference_active;
      en = bus.nn_req;
      s  = model_pick(eh, en);
      we = (s == M_HOST) ? bus.host_we : (s == M_NN) ? bus.nn_we : 1'b0;
      a  = (s == M_HOST) ? int'(bus.host_addr) : (s == M_NN) ? int'(bus.nn_addr) : 0;
      d  = (s == M_HOST) ? int'(bus.host_wd) : (s == M_NN) ? int'(bus.nn_wd) : 0;
      chk("host_gnt", bus.host_gnt, int'(s == M_HOST));
      chk("nn_gnt", bus.nn_gnt, int'(s == M_NN));
      chk("ram_we", bus.RAM_we, int'(we));
      chk("ram_addr", bus.RAM_address, a);
      chk("ram_wd", bus.RAM_wd, we ? d : ((s == M_NONE) ? 0 : int'(bus.RAM_wd)));
      chk("busy", bus.busy, int'(m_owner != M_NONE));
      if (s != M_NONE) begin
        if (we) m_mem[a] = DW'(d);
        else q.push_back('{who: s, data: int'(m_mem[a]), due: cyc + 1});
      end
      if (s == M_NONE) m_streak = 0;
      else if (s != m_owner) m_streak = 1;
      else m_streak = (m_streak < 255) ? m_streak + 1 : 255;
      if (s != M_NONE) m_last = s;
      m_owner = s;
    end
  end

  // Read-response monitor.
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      chk("rst_host_rvalid", bus.host_rvalid, 0);
      chk("rst_nn_rvalid", bus.nn_rvalid, 0);
      chk("rst_host_rd", bus.host_rd, 0);
      chk("rst_nn_rd", bus.nn_rd, 0);
    end else begin
      if (bus.host_rvalid && bus.nn_rvalid)
        chk("both_rvalid", 1, 0);
      if (bus.host_rvalid || bus.nn_rvalid) begin
        if (q.size() == 0) begin
          chk("unexpected_rvalid", 1, 0);
        end else begin
          rsp_t e;
          e = q.pop_front();
          chk("rsp_who", bus.host_rvalid ? M_HOST : M_NN, e.who);
          chk("rsp_data", bus.host_rvalid ? int'(bus.host_rd) : int'(bus.nn_rd), e.data);
          chk("rsp_cycle", cyc, e.due);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_rvalid", 0, 1);
        void'(q.pop_front());
      end
      if (!bus.host_rvalid) chk("host_rd_idle", bus.host_rd, 0);
      if (!bus.nn_rvalid)   chk("nn_rd_idle", bus.nn_rd, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_h(input bit req, input bit we, input int addr, input int wd);
    bus.host_req = req; bus.host_we = we;
    bus.host_addr = AW'(addr); bus.host_wd = DW'(wd);
  endtask

  task automatic set_n(input bit req, input bit we, input int addr, input int wd);
    bus.nn_req = req; bus.nn_we = we;
    bus.nn_addr = AW'(addr); bus.nn_wd = DW'(wd);
  endtask

  initial begin
    reset = 1'b0;
    bus.inference_active = 1'b0;
    set_h(0, 0, 0, 0);
    set_n(0, 0, 0, 0);
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]   = DW'($urandom);
      m_mem[i] = ram[i];
    end
    ram[5] = 8'hA7; m_mem[5] = 8'hA7;
    tick(2);
    reset = 1'b1;
    tick(1);

    // Idle host single read of preloaded 0xA7.
    set_h(1, 0, 'h005, 0); tick(1);
    set_h(0, 0, 0, 0);     tick(2);

    // Tie: NN first, then host once NN drops.
    set_h(1, 0, 'h020, 0); set_n(1, 0, 'h021, 0); tick(2);
    set_n(0, 0, 0, 0); tick(1);
    set_h(0, 0, 0, 0); tick(2);

    // Burst cap with both sides streaming.
    set_h(1, 0, 'h030, 0); set_n(1, 0, 'h031, 0); tick(14);
    set_h(0, 0, 0, 0); set_n(0, 0, 0, 0); tick(2);

    // Inference lock, then host write and read-back at 0x3FF.
    bus.inference_active = 1'b1;
    set_h(1, 1, 'h3FF, 'h3C); tick(20);
    bus.inference_active = 1'b0; tick(1);
    set_h(1, 0, 'h3FF, 0); tick(1);
    set_h(0, 0, 0, 0); tick(2);

    // Interleaved reads.
    set_h(1, 0, 'h010, 0); tick(1);
    set_h(0, 0, 0, 0); set_n(1, 0, 'h011, 0); tick(1);
    set_n(0, 0, 0, 0); tick(2);

    // Long single-side stream saturates the burst counter; host must get in at once.
    set_n(1, 0, 'h040, 0); tick(300);
    set_h(1, 0, 'h041, 0); tick(3);
    set_h(0, 0, 0, 0); set_n(0, 0, 0, 0); tick(2);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.inference_active = ~bus.inference_active;
      set_h($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1023), $urandom_range(0, 255));
      set_n($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1023), $urandom_range(0, 255));
      tick(1);
    end
    bus.inference_active = 1'b0;
    set_h(0, 0, 0, 0); set_n(0, 0, 0, 0); tick(2);

    // Reset in the cycle after a granted NN read: response dropped.
    set_h(1, 0, 'h050, 0); set_n(1, 0, 'h051, 0);
    bus.inference_active = 1'b1; tick(1);
    reset = 1'b0; tick(2);
    bus.inference_active = 1'b0;
    reset = 1'b1; tick(1);
    set_h(0, 0, 0, 0); set_n(0, 0, 0, 0); tick(3);

    if (q.size() != 0) chk("pending_at_end", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
